// File: rtl/arbitro_rr_decod_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface arbitro_rr_decod_4_if;
  logic req0;
  logic req1;
  logic req2;
  logic req3;
  logic gnt0;
  logic gnt1;
  logic gnt2;
  logic gnt3;
  logic idx_a;
  logic idx_b;
  logic ocupado;
  logic estouro;

  modport master (
    output req0, req1, req2, req3,
    input  gnt0, gnt1, gnt2, gnt3, idx_a, idx_b, ocupado, estouro
  );

  modport slave (
    input  req0, req1, req2, req3,
    output gnt0, gnt1, gnt2, gnt3, idx_a, idx_b, ocupado, estouro
  );
endinterface

// File: rtl/arbitro_rr_decod_4.sv
// Round-robin arbiter for four scalar requesters. The registered 2-bit winner
// index feeds 2->4 decoder equations to form a one-hot grant. A grant lasts
// while its owner keeps requesting or until the optional hold timeout, and
// every grant is followed by one idle cycle before the next one is issued.
module arbitro_rr_decod_4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  arbitro_rr_decod_4_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    CONCEDIDO = 2'b01,
    LIBERA    = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  state_t           state;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       ptr;
  logic [1:0]       idx;
  logic [1:0]       winner;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             ocupado;
  logic             estouro;

  // 2->4 decoder: Y(K) high only for index K
  function automatic logic [3:0] decode(input logic [1:0] sel);
    logic [3:0] y;
    y[0] = ~sel[1] & ~sel[0];
    y[1] = ~sel[1] &  sel[0];
    y[2] =  sel[1] & ~sel[0];
    y[3] =  sel[1] &  sel[0];
    return y;
  endfunction

  assign req = {bus.req3, bus.req2, bus.req1, bus.req0};

  // Rotating-priority search: ptr+1, ptr+2, ptr+3, then ptr itself last
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && req[2'(ptr + 2'(i))]) begin
        winner = 2'(ptr + 2'(i));
        found  = 1'b1;
      end
    end
  end

  // Grant sequencing FSM; all outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OCIOSO;
      gnt     <= '0;
      idx     <= '0;
      ptr     <= 2'd3;
      cnt     <= '0;
      ocupado <= 1'b0;
      estouro <= 1'b0;
    end else begin
      estouro <= 1'b0;
      unique case (state)
        OCIOSO, LIBERA: begin
          if (found) begin
            state   <= CONCEDIDO;
            idx     <= winner;
            gnt     <= decode(winner);
            cnt     <= CNT_W'(1);
            ocupado <= 1'b1;
          end else begin
            state   <= OCIOSO;
          end
        end
        CONCEDIDO: begin
          // Release takes precedence over timeout when both happen on one edge
          if (!req[idx]) begin
            state   <= LIBERA;
            gnt     <= '0;
            ptr     <= idx;
            ocupado <= 1'b0;
          end else if (HOLD_EN && cnt == HOLD_LIM) begin
            state   <= LIBERA;
            gnt     <= '0;
            ptr     <= idx;
            ocupado <= 1'b0;
            estouro <= 1'b1;
          end else if (HOLD_EN) begin
            cnt     <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= OCIOSO;
          gnt     <= '0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.gnt2    = gnt[2];
  assign bus.gnt3    = gnt[3];
  assign bus.idx_a   = idx[1];
  assign bus.idx_b   = idx[0];
  assign bus.ocupado = ocupado;
  assign bus.estouro = estouro;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_decode: assert property (@(posedge clk) disable iff (rst) ocupado |-> (gnt == decode(idx)));
  a_idle:   assert property (@(posedge clk) disable iff (rst) !ocupado |-> (gnt == 4'b0000));
  a_cnt:    assert property (@(posedge clk) disable iff (rst) HOLD_EN |-> (cnt <= HOLD_LIM));

endmodule

// File: tb/tb_arbitro_rr_decod_4.sv
// Bench for arbitro_rr_decod_4: two instances (hold timeout 4 and no timeout)
// driven with identical requests; a behavioural model pushes expected outputs
// into per-instance queues that are popped after each clock edge.
module tb_arbitro_rr_decod_4;

  localparam int MH         = 4;
  localparam int STARVE_LIM = 3 * (MH + 1) + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arbitro_rr_decod_4_if if4 ();
  arbitro_rr_decod_4_if if0 ();

  arbitro_rr_decod_4 #(.MAX_HOLD(MH), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  arbitro_rr_decod_4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  typedef struct {
    int owner;  // -1 when nobody holds the resource
    int last;   // last requester whose grant ended
    int idx;
    int hold;
    bit ovf;
  } model_t;

  typedef struct packed {
    logic       estouro;
    logic       ocupado;
    logic [1:0] idx;
    logic [3:0] gnt;
  } out_t;

  model_t m4;
  model_t m0;
  out_t   sb4[$];
  out_t   sb0[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(output model_t s);
    s.owner = -1;
    s.last  = 3;
    s.idx   = 0;
    s.hold  = 0;
    s.ovf   = 1'b0;
  endtask

  task automatic model_step(inout model_t s, input logic [3:0] r, input int mh);
    s.ovf = 1'b0;
    if (s.owner >= 0) begin
      if (!r[s.owner]) begin
        s.last  = s.owner;
        s.owner = -1;
      end else if (mh != 0 && s.hold == mh) begin
        s.last  = s.owner;
        s.owner = -1;
        s.ovf   = 1'b1;
      end else begin
        s.hold++;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (s.last + k) % 4;
        if (s.owner < 0 && r[c]) begin
          s.owner = c;
          s.idx   = c;
          s.hold  = 1;
        end
      end
    end
  endtask

  function automatic out_t expect_of(input model_t s);
    out_t o;
    o.estouro = s.ovf;
    o.ocupado = (s.owner >= 0);
    o.idx     = 2'(s.idx);
    o.gnt     = (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0000;
    return o;
  endfunction

  function automatic out_t obs4();
    return {if4.estouro, if4.ocupado, if4.idx_a, if4.idx_b, if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0};
  endfunction

  function automatic out_t obs0();
    return {if0.estouro, if0.ocupado, if0.idx_a, if0.idx_b, if0.gnt3, if0.gnt2, if0.gnt1, if0.gnt0};
  endfunction

  task automatic compare_out(input string name, input out_t got, input out_t exp);
    check_eq({name, ".gnt"},     32'(got.gnt),     32'(exp.gnt));
    check_eq({name, ".idx"},     32'(got.idx),     32'(exp.idx));
    check_eq({name, ".ocupado"}, 32'(got.ocupado), 32'(exp.ocupado));
    check_eq({name, ".estouro"}, 32'(got.estouro), 32'(exp.estouro));
  endtask

  task automatic drive(input logic [3:0] r);
    {if4.req3, if4.req2, if4.req1, if4.req0} = r;
    {if0.req3, if0.req2, if0.req1, if0.req0} = r;
  endtask

  // One clock: drive at negedge, push model expectation, pop and compare after the edge
  task automatic step(input logic [3:0] r);
    out_t e;
    @(negedge clk);
    drive(r);
    model_step(m4, r, MH);
    model_step(m0, r, 0);
    sb4.push_back(expect_of(m4));
    sb0.push_back(expect_of(m0));
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    compare_out("mh4", obs4(), e);
    e = sb0.pop_front();
    compare_out("mh0", obs0(), e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] prev_g;
    logic [3:0] one;
    int         seq[$];
    int         order[5];
    int         est_cnt;
    int         hi_cnt;
    bit         prev_oc;
    int         wait_c[4];
    int         max_wait;

    one   = 4'b0001;
    order = '{0, 1, 2, 3, 0};

    // Reset state
    rst = 1'b1;
    drive(4'b0000);
    model_reset(m4);
    model_reset(m0);
    #12;
    compare_out("rst_mh4", obs4(), expect_of(m4));
    compare_out("rst_mh0", obs0(), expect_of(m0));
    @(negedge clk);
    rst = 1'b0;

    // All requesters held: 4-cycle grants, gap with estouro, order 0,1,2,3,0
    prev_oc = 1'b0;
    est_cnt = 0;
    for (int n = 0; n < 22; n++) begin
      step(4'b1111);
      if (if4.ocupado && !prev_oc) seq.push_back(int'({if4.idx_a, if4.idx_b}));
      if (if4.estouro) est_cnt++;
      prev_oc = if4.ocupado;
    end
    check_eq("t1_grants", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) check_eq($sformatf("t1_order%0d", i), seq[i], order[i]);
    check_eq("t1_estouro_pulses", est_cnt, 4);
    repeat (3) step(4'b0000);

    // req2 alone, then req0+req3 together after req2 was served
    step(4'b0100);
    check_eq("t2_gnt2", {if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0}, 4'b0100);
    check_eq("t2_idx", {if4.idx_a, if4.idx_b}, 2'b10);
    repeat (2) step(4'b0100);
    step(4'b0000);
    check_eq("t2_gnt2_fall", if4.gnt2, 1'b0);
    step(4'b0000);
    step(4'b1001);
    check_eq("t2_gnt3_wins", {if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0}, 4'b1000);
    repeat (2) step(4'b0000);

    // Release on the same edge the hold limit is reached: no estouro
    repeat (4) step(4'b0010);
    check_eq("t3_held", if4.ocupado, 1'b1);
    step(4'b0000);
    check_eq("t3_ocupado", if4.ocupado, 1'b0);
    check_eq("t3_estouro", if4.estouro, 1'b0);
    step(4'b0000);

    // Async reset mid-grant, then fresh priority order
    repeat (2) step(4'b1000);
    check_eq("t4_gnt3", {if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0}, 4'b1000);
    #1 rst = 1'b1;
    #1;
    model_reset(m4);
    model_reset(m0);
    compare_out("t4_rst_mh4", obs4(), expect_of(m4));
    compare_out("t4_rst_mh0", obs0(), expect_of(m0));
    #1 rst = 1'b0;
    step(4'b0011);
    check_eq("t4_gnt0_wins", {if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0}, 4'b0001);
    repeat (2) step(4'b0000);

    // Random held requests with invariant and starvation checks
    r        = 4'b0000;
    prev_g   = 4'b0000;
    max_wait = 0;
    for (int k = 0; k < 4; k++) wait_c[k] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (m4.owner == k) begin
          if ($urandom_range(3) == 0) r[k] = 1'b0;
        end else if (!r[k]) begin
          if ($urandom_range(2) == 0) r[k] = 1'b1;
        end
      end
      step(r);
      g = {if4.gnt3, if4.gnt2, if4.gnt1, if4.gnt0};
      check_eq("t5_onehot", 32'($onehot0(g)), 32'd1);
      if (if4.ocupado) check_eq("t5_decode", g, one << {if4.idx_a, if4.idx_b});
      else             check_eq("t5_idle_zero", g, 4'b0000);
      if (prev_g != 4'b0000 && g != 4'b0000) check_eq("t5_gap", g, prev_g);
      prev_g = g;
      for (int k = 0; k < 4; k++) begin
        if (r[k] && !g[k]) wait_c[k]++;
        else               wait_c[k] = 0;
        if (wait_c[k] > max_wait) max_wait = wait_c[k];
      end
    end
    check_eq("t5_starvation", 32'(max_wait <= STARVE_LIM), 32'd1);
    repeat (3) step(4'b0000);

    // No timeout: req1 held for 100 cycles keeps its grant throughout
    hi_cnt  = 0;
    est_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      step(4'b0010);
      if (if0.gnt1) hi_cnt++;
      if (if0.estouro) est_cnt++;
    end
    check_eq("t6_gnt1_cycles", hi_cnt, 100);
    check_eq("t6_no_estouro", est_cnt, 0);
    repeat (2) step(4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
